// File: rtl/tinker_mem_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package tinker_mem_pkg;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int MAX_STARVE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_e;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared memory port of the arbiter as one bundle.
interface mem_port_arbiter_if
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requester and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_prio_sel.sv
// Data-first priority select with a saturating fetch-starvation counter that
// forces a fetch grant once data has won MAX_STARVE times in a row.
module mem_arb_prio_sel
  import tinker_mem_pkg::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int              CNT_W   = cnt_width(MAX_STARVE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             fetch_wins;

  always_comb begin
    fetch_wins   = if_req && (!d_req || (starve_cnt_q == CNT_MAX));
    if_gnt       = arb_en && fetch_wins;
    d_gnt        = arb_en && d_req && !fetch_wins;
    starve_cnt_d = starve_cnt_q;
    if (if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && if_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester;
// one access in flight at a time, completion reported as a one-cycle valid.
module mem_port_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              arb_en;
  logic              if_gnt;
  logic              d_gnt;

  assign arb_en = (state_q == IDLE);
  assign busy   = (state_q != IDLE);

  mem_arb_prio_sel #(
    .MAX_STARVE (MAX_STARVE)
  ) u_prio_sel (
    .clk     (clk),
    .reset_n (reset_n),
    .arb_en  (arb_en),
    .if_req  (bus.if_req),
    .d_req   (bus.d_req),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        // mem_ready/mem_rdata are deliberately not looked at here.
        if (if_gnt) begin
          state_d = I_XFER;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end else if (d_gnt) begin
          state_d = D_XFER;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
        end
      end
      I_XFER: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          if_valid_d = 1'b1;
          if_rdata_d = bus.mem_rdata[31:0];
        end
      end
      D_XFER: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = busy;
  assign bus.mem_we    = (state_q == D_XFER) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: requester agents push expected responses at grant time, a
// negedge monitor checks grants, memory-port activity and completions.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MS  = 4;

  logic clk;
  logic reset_n;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MAX_STARVE (MS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] f_exp_q[$];
  logic [63:0] d_exp_q[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] env_mem[logic [63:0]];
  logic [63:0] last_load;

  // Monitor-side reference state.
  bit          m_busy;
  bit          m_kind_d;
  bit          m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  int          m_starve;
  int          m_vnext;      // 0 none, 1 fetch valid due, 2 data valid due
  int          we_cyc;
  string       gnt_log;

  int          fixed_wait;   // <0: random memory latency, else fixed wait count
  int          xfer_cyc;
  bit          prev_req;

  function automatic logic [63:0] mem_init(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] exp_w, output int waited);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.if_gnt) break;
      waited++;
      if (waited > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL if_gnt_timeout: got no grant want grant within 300 cycles");
        break;
      end
    end
    if (bus.if_gnt) f_exp_q.push_back(exp_w);
    $display("fetch  addr=%0h waited=%0d exp=%0h", addr, waited, exp_w);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    int          waited;
    logic [63:0] exp;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.d_gnt) break;
      waited++;
      if (waited > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL d_gnt_timeout: got no grant want grant within 300 cycles");
        break;
      end
    end
    if (bus.d_gnt) begin
      if (we) begin
        ref_mem[addr] = wdata;
        exp = last_load;
      end else begin
        exp = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
        last_load = exp;
      end
      d_exp_q.push_back(exp);
    end
    $display("data   we=%0d addr=%0h wdata=%0h waited=%0d", we, addr, wdata, waited);
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((f_exp_q.size() != 0 || d_exp_q.size() != 0 || m_busy || m_vnext != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", f_exp_q.size() + d_exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Memory model: latency either fixed or random; mem_ready also toggles in IDLE.
  always @(posedge clk) begin
    #1;
    if (bus.mem_req) xfer_cyc = prev_req ? xfer_cyc + 1 : 0;
    prev_req = bus.mem_req;
    if (fixed_wait < 0) bus.mem_ready = ($urandom_range(0, 2) == 0);
    else                bus.mem_ready = bus.mem_req && (xfer_cyc == fixed_wait);
    if (bus.mem_req && !bus.mem_we)
      bus.mem_rdata = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : mem_init(bus.mem_addr);
    else
      bus.mem_rdata = {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (reset_n && bus.mem_req && bus.mem_ready && bus.mem_we)
      env_mem[bus.mem_addr] = bus.mem_wdata;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit exp_i;
    bit exp_d;
    if (!reset_n) begin
      if (m_busy) begin
        if (m_kind_d) void'(d_exp_q.pop_front());
        else          void'(f_exp_q.pop_front());
      end
      m_busy   = 1'b0;
      m_starve = 0;
      m_vnext  = 0;
      chk("rst_busy",     busy,         1'b0);
      chk("rst_mem_req",  bus.mem_req,  1'b0);
      chk("rst_mem_we",   bus.mem_we,   1'b0);
      chk("rst_if_valid", bus.if_valid, 1'b0);
      chk("rst_d_valid",  bus.d_valid,  1'b0);
    end else begin
      chk("busy",    busy,        m_busy);
      chk("mem_req", bus.mem_req, m_busy);
      chk("mem_we",  bus.mem_we,  m_busy && m_kind_d && m_we);
      if (m_busy) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_kind_d && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("if_valid", bus.if_valid, m_vnext == 1);
      chk("d_valid",  bus.d_valid,  m_vnext == 2);
      if (bus.if_valid && m_vnext == 1) begin
        if (f_exp_q.size() == 0) chk("if_queue", 1'b1, 1'b0);
        else                     chk("if_rdata", bus.if_rdata, f_exp_q.pop_front());
      end
      if (bus.d_valid && m_vnext == 2) begin
        if (d_exp_q.size() == 0) chk("d_queue", 1'b1, 1'b0);
        else                     chk("d_rdata", bus.d_rdata, d_exp_q.pop_front());
      end
      if (bus.mem_we) we_cyc++;
      if (bus.if_gnt) gnt_log = {gnt_log, "I"};
      if (bus.d_gnt)  gnt_log = {gnt_log, "D"};

      m_vnext = 0;
      if (m_busy) begin
        chk("if_gnt_busy", bus.if_gnt, 1'b0);
        chk("d_gnt_busy",  bus.d_gnt,  1'b0);
        if (bus.mem_ready) begin
          m_busy  = 1'b0;
          m_vnext = m_kind_d ? 2 : 1;
        end
      end else begin
        exp_i = bus.if_req && (!bus.d_req || m_starve == MS);
        exp_d = bus.d_req && !exp_i;
        chk("if_gnt", bus.if_gnt, exp_i);
        chk("d_gnt",  bus.d_gnt,  exp_d);
        if (exp_i) begin
          m_busy   = 1'b1;
          m_kind_d = 1'b0;
          m_we     = 1'b0;
          m_addr   = bus.if_addr;
          m_starve = 0;
        end else if (exp_d) begin
          m_busy   = 1'b1;
          m_kind_d = 1'b1;
          m_we     = bus.d_we;
          m_addr   = bus.d_addr;
          m_wdata  = bus.d_wdata;
          if (bus.if_req && m_starve < MS) m_starve++;
        end
      end
    end
  end

  initial begin
    int          w_f;
    int          w_g;
    logic [63:0] fa;
    logic [63:0] fi;
    logic [63:0] da;
    int          gap_f;
    int          gap_d;

    reset_n       = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    fixed_wait    = 0;
    xfer_cyc      = 0;
    prev_req      = 1'b0;
    last_load     = '0;
    we_cyc        = 0;
    gnt_log       = "";
    m_busy        = 1'b0;
    m_starve      = 0;
    m_vnext       = 0;

    repeat (2) @(negedge clk);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata",  bus.d_rdata,  64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fetch only, zero wait, issued in the first cycle out of reset.
    env_mem[64'h2000] = 64'h0000_0000_8840_0001;
    do_fetch(64'h2000, 32'h8840_0001, w_f);
    chk("first_gnt_wait", w_f, 0);
    drain();

    // Store with three wait cycles, then read it back.
    fixed_wait = 3;
    we_cyc = 0;
    do_data(1'b1, 64'h7FFF8, 64'h2004);
    drain();
    chk("store_we_cycles", we_cyc, 4);
    do_data(1'b0, 64'h7FFF8, 64'h0);
    drain();

    // Simultaneous requests: data first, fetch granted on the data valid cycle.
    fixed_wait = 1;
    gnt_log = "";
    fi = mem_init(64'h1000_0040);
    fork
      do_fetch(64'h1000_0040, fi[31:0], w_g);
      do_data(1'b0, 64'h80000, 64'h0);
    join
    drain();
    n_cmp++;
    if (gnt_log != "DI") begin
      n_err++;
      $display("FAIL simul_order: got %s want DI", gnt_log);
    end

    // Random traffic with random latency; mem_ready also pulses while idle.
    fixed_wait = -1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          fa = 64'h1000_0000 + 64'(4 * $urandom_range(0, 63));
          fi = mem_init(fa);
          do_fetch(fa, fi[31:0], w_f);
          gap_f = $urandom_range(0, 3);
          if (gap_f != 0) begin
            repeat (gap_f) @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          da = 64'h80000 + 64'(8 * $urandom_range(0, 15));
          do_data(1'($urandom_range(0, 1)), da, {$urandom, $urandom});
          gap_d = $urandom_range(0, 3);
          if (gap_d != 0) begin
            repeat (gap_d) @(posedge clk);
            #1;
          end
        end
      end
    join
    drain();
    repeat (10) @(posedge clk);
    #1;

    // Reset while a load is in flight: access is dropped without a valid.
    fixed_wait = 1000;
    do_data(1'b0, 64'h80008, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_busy",    busy,        1'b0);
    chk("abort_d_valid", bus.d_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    last_load  = '0;
    fixed_wait = 0;

    // Both requesting back to back: D,D,D,D,I repeating.
    gnt_log = "";
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          fa = 64'h1000_0100 + 64'(4 * k);
          fi = mem_init(fa);
          do_fetch(fa, fi[31:0], w_g);
        end
      end
      begin
        for (int m = 0; m < 8; m++) do_data(1'b0, 64'h80000 + 64'(8 * m), 64'h0);
      end
    join
    drain();
    n_cmp++;
    if (gnt_log != "DDDDIDDDDI") begin
      n_err++;
      $display("FAIL starve_order: got %s want DDDDIDDDDI", gnt_log);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
